// File: rtl/rot_seq_ctrl.sv
// Rotation sequencer: load, paced rotation steps, dual BCD conversion handshake.
// Optional conversion timeout with sticky err flag when ROT_SEQ_TIMEOUT_EN is defined.
module rot_seq_ctrl #(
  parameter int STEP_DIV = 250,
  parameter int NW       = 6,
  parameter int TO_MS    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          abort,
  input  logic          cont,
  input  logic [NW-1:0] nsteps,
  input  logic          ce1ms,
  input  logic          conv_ok_re,
  input  logic          conv_ok_im,
  output logic          ld,
  output logic          st,
  output logic          conv_st,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] step_cnt,
  output logic          err
);

  localparam int TW = $clog2(STEP_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP, S_CONV, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          ld_q, ld_d, st_q, st_d, conv_st_q, conv_st_d;
  logic          done_q, done_d, busy_q, busy_d;
  logic          first_q, first_d;
  logic [NW-1:0] step_cnt_q, step_cnt_d, nsteps_q, nsteps_d;
  logic [TW-1:0] tick_q, tick_d;
`ifdef ROT_SEQ_TIMEOUT_EN
  localparam int TOW = $clog2(TO_MS + 1);
  logic           err_q, err_d;
  logic [TOW-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d    = state_q;
    ld_d       = 1'b0;
    st_d       = 1'b0;
    conv_st_d  = 1'b0;
    done_d     = 1'b0;
    first_d    = first_q;
    step_cnt_d = step_cnt_q;
    nsteps_d   = nsteps_q;
    tick_d     = tick_q;
`ifdef ROT_SEQ_TIMEOUT_EN
    err_d      = err_q;
    to_d       = to_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          nsteps_d   = nsteps;
          step_cnt_d = '0;
          ld_d       = 1'b1;
          state_d    = S_LOAD;
`ifdef ROT_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
        S_LOAD: begin
          tick_d = '0;
          // An empty run skips STEP so conv_st follows ld directly.
          if (nsteps_q == '0) begin
            conv_st_d = 1'b1;
            state_d   = S_CONV;
          end else begin
            state_d   = S_STEP;
          end
        end
        S_STEP: begin
          if (step_cnt_q == nsteps_q) begin
            conv_st_d = 1'b1;
            state_d   = S_CONV;
          end else if (ce1ms) begin
            if (tick_q == TW'(STEP_DIV - 1)) begin
              st_d       = 1'b1;
              tick_d     = '0;
              step_cnt_d = step_cnt_q + 1'b1;
            end else begin
              tick_d     = tick_q + 1'b1;
            end
          end
        end
        S_CONV: begin
          first_d = 1'b1;
          state_d = S_WAIT;
`ifdef ROT_SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end
        S_WAIT: begin
          // Converters may still show the previous result right after conv_st.
          first_d = 1'b0;
          if (!first_q && conv_ok_re && conv_ok_im) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
`ifdef ROT_SEQ_TIMEOUT_EN
          else if (ce1ms) begin
            if (to_q == TOW'(TO_MS - 1)) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              to_d    = to_q + 1'b1;
            end
          end
`endif
        end
        S_DONE: begin
          if (cont) begin
            step_cnt_d = '0;
            tick_d     = '0;
            state_d    = S_STEP;
          end else begin
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      conv_st_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      step_cnt_q <= '0;
      nsteps_q   <= '0;
      tick_q     <= '0;
`ifdef ROT_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      conv_st_q  <= conv_st_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      first_q    <= first_d;
      step_cnt_q <= step_cnt_d;
      nsteps_q   <= nsteps_d;
      tick_q     <= tick_d;
`ifdef ROT_SEQ_TIMEOUT_EN
      err_q      <= err_d;
      to_q       <= to_d;
`endif
    end
  end

  assign ld       = ld_q;
  assign st       = st_q;
  assign conv_st  = conv_st_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign step_cnt = step_cnt_q;
`ifdef ROT_SEQ_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
